// File: rtl/clk_enable_gen.sv
// clk_enable_gen: qualifies raw PLL lock, then drives NCH programmable clock-enable strobes and 50% toggle outputs.
//
// Ports:
//   clk             fabric clock (CCC GL0)
//   rst             synchronous reset, active high
//   pll_lock_i      raw CCC LOCK, asynchronous to clk
//   locked_o        qualified lock, registered (state == LOCKED)
//   div_wr_i        divisor write strobe, one cycle
//   div_ch_i        channel being written (values >= NCH are acked and ignored)
//   div_val_i       new divisor (0 and 1 both mean "every cycle")
//   div_ack_o       write accepted, one cycle after div_wr_i
//   ce_o            one-cycle clock-enable strobes, one per channel
//   sq_o            square outputs, toggle on each ce
//   lockloss_cnt_o  saturating LOCKED->UNLOCKED count when CLKGEN_LOCKLOSS_CNT_EN
//                   is defined, otherwise tied to zero
//
// Optional feature macro: CLKGEN_LOCKLOSS_CNT_EN
module clk_enable_gen #(
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int DIV_W     = 16,
  parameter int DIV_RST   = 2,
  parameter int LOCK_QUAL = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock_i,
  output logic             locked_o,
  input  logic             div_wr_i,
  input  logic [CH_W-1:0]  div_ch_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic             div_ack_o,
  output logic [NCH-1:0]   ce_o,
  output logic [NCH-1:0]   sq_o,
  output logic [7:0]       lockloss_cnt_o
);
  localparam int QW = $clog2(LOCK_QUAL);
  typedef enum logic [1:0] {UNLOCKED, QUALIFY, LOCKED} state_t;
  state_t state, state_nx;
  logic [QW-1:0] qcnt, qcnt_nx;
  logic lk_m, lk_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_m      <= 1'b0;
      lk_s      <= 1'b0;
      state     <= UNLOCKED;
      qcnt      <= '0;
      locked_o  <= 1'b0;
      div_ack_o <= 1'b0;
    end else begin
      lk_m      <= pll_lock_i;
      lk_s      <= lk_m;
      state     <= state_nx;
      qcnt      <= qcnt_nx;
      locked_o  <= state == LOCKED;
      div_ack_o <= div_wr_i;
    end
  end
  // The cycle that leaves UNLOCKED already saw lk_s high, so it counts as
  // the first qualifying cycle and qcnt starts at 1.
  always_comb begin
    state_nx = state;
    qcnt_nx  = '0;
    case (state)
      UNLOCKED: begin
        state_nx = lk_s ? QUALIFY : UNLOCKED;
        qcnt_nx  = lk_s ? QW'(1) : '0;
      end
      QUALIFY: begin
        state_nx = !lk_s ? UNLOCKED : qcnt == QW'(LOCK_QUAL - 1) ? LOCKED : QUALIFY;
        qcnt_nx  = (lk_s && qcnt != QW'(LOCK_QUAL - 1)) ? qcnt + 1'b1 : '0;
      end
      LOCKED:  state_nx = lk_s ? LOCKED : UNLOCKED;
      default: state_nx = UNLOCKED;
    endcase
  end
`ifdef CLKGEN_LOCKLOSS_CNT_EN
  logic [7:0] ll_cnt;
  always_ff @(posedge clk) begin
    if (rst)
      ll_cnt <= '0;
    else if (state == LOCKED && state_nx == UNLOCKED && ll_cnt != 8'hff)
      ll_cnt <= ll_cnt + 1'b1;
  end
  assign lockloss_cnt_o = ll_cnt;
`else
  assign lockloss_cnt_o = 8'h00;
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt, div, pend;
    logic pf, ce, sq, hit, term;
    assign hit  = div_wr_i && div_ch_i == CH_W'(i);
    assign term = locked_o && (div <= DIV_W'(1) || cnt == div - 1'b1);
    // A write landing on the terminal cycle bypasses pend; otherwise pend is
    // adopted at the next terminal count, or at once while unlocked.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt  <= '0;
        div  <= DIV_W'(DIV_RST);
        pend <= '0;
        pf   <= 1'b0;
        ce   <= 1'b0;
        sq   <= 1'b0;
      end else begin
        cnt <= (!locked_o || term) ? '0 : cnt + 1'b1;
        ce  <= term;
        sq  <= locked_o && (sq ^ term);
        if (hit && term) begin
          div <= div_val_i;
          pf  <= 1'b0;
        end else if (hit) begin
          pend <= div_val_i;
          pf   <= 1'b1;
        end else if (pf && (!locked_o || term)) begin
          div <= pend;
          pf  <= 1'b0;
        end
      end
    end
    assign ce_o[i] = ce;
    assign sq_o[i] = sq;
  end
endmodule
